// File: rtl/mac_pkg.sv
// mac_pkg: shared types and default sizes
// for the sequential MAC accumulator.
package mac_pkg;

  localparam int MAC_BIT_WIDTH  = 8;
  localparam int MAC_ACCUM_BITS = 32;
  localparam int MAC_LEN_BITS   = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    DONE
  } mac_state_e;

endpackage

// File: rtl/mac_seq_accum_top.sv
// top: combinational unsigned MAC,
// partial_sum_out = partial_sum_in + weight*inp.
module top
  import mac_pkg::*;
#(
  parameter int BIT_WIDTH  = MAC_BIT_WIDTH,
  parameter int ACCUM_BITS = MAC_ACCUM_BITS
) (
  input  logic [BIT_WIDTH-1:0]  weight,
  input  logic [BIT_WIDTH-1:0]  inp,
  input  logic [ACCUM_BITS-1:0] partial_sum_in,
  output logic [ACCUM_BITS-1:0] partial_sum_out
);

  logic [2*BIT_WIDTH-1:0] prod;

  assign prod = {{BIT_WIDTH{1'b0}}, weight}
              * {{BIT_WIDTH{1'b0}}, inp};

  assign partial_sum_out =
    partial_sum_in + ACCUM_BITS'(prod);

endmodule

// File: rtl/mac_seq_accum.sv
// mac_seq_accum: streams a vector of operand pairs
// through the MAC and returns one dot product.
module mac_seq_accum
  import mac_pkg::*;
#(
  parameter int BIT_WIDTH  = MAC_BIT_WIDTH,
  parameter int ACCUM_BITS = MAC_ACCUM_BITS,
  parameter int LEN_BITS   = MAC_LEN_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_BITS-1:0]   vec_len,
  input  logic [ACCUM_BITS-1:0] init_sum,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIT_WIDTH-1:0]  weight,
  input  logic [BIT_WIDTH-1:0]  inp,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACCUM_BITS-1:0] out_sum,
  output logic                  busy
);

  mac_state_e state_q, state_d;

  logic [LEN_BITS-1:0]   cnt_q;
  logic [BIT_WIDTH-1:0]  w_q;
  logic [BIT_WIDTH-1:0]  i_q;
  logic                  v_q;
  logic [ACCUM_BITS-1:0] acc_q;
  logic [ACCUM_BITS-1:0] mac_out;
  logic                  out_valid_q;
  logic [ACCUM_BITS-1:0] out_sum_q;
  logic                  load;
  logic                  xfer;
  logic                  last;

  assign load = (state_q == IDLE) && start;
  assign xfer = in_valid && in_ready;
  assign last = (cnt_q == LEN_BITS'(1));

  top #(
    .BIT_WIDTH  (BIT_WIDTH),
    .ACCUM_BITS (ACCUM_BITS)
  ) u_mac (
    .weight          (w_q),
    .inp             (i_q),
    .partial_sum_in  (acc_q),
    .partial_sum_out (mac_out)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b1;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (vec_len == '0) state_d = DONE;
          else               state_d = ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && last) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        if (out_valid_q && out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Remaining-pair counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt_q <= '0;
    else if (load) cnt_q <= vec_len;
    else if (xfer) cnt_q <= cnt_q - LEN_BITS'(1);
  end

  // Operand stage: one pending pair feeds the MAC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= '0;
      i_q <= '0;
      v_q <= 1'b0;
    end else begin
      v_q <= xfer;
      if (xfer) begin
        w_q <= weight;
        i_q <= inp;
      end
    end
  end

  // Accumulator: seeded on start, absorbs pending pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     acc_q <= '0;
    else if (load)  acc_q <= init_sum;
    else if (v_q)   acc_q <= mac_out;
  end

  // Result register, held until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
    end else if (state_q == DONE) begin
      if (!out_valid_q) begin
        out_valid_q <= 1'b1;
        out_sum_q   <= acc_q;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;

endmodule

// File: doc/mac_seq_accum.md
# mac_seq_accum

Sequential streaming wrapper around the existing combinational MAC (`top`: `partial_sum_out = partial_sum_in + weight*inp`). It drives the MAC's `partial_sum_in` from its own accumulator and consumes `partial_sum_out`. The block accepts a programmed-length vector of (weight, inp) pairs over a valid/ready handshake and returns a single dot-product result over a second handshake. It replaces file-driven stimulus with an in-fabric accumulation loop for MAC characterisation and accelerator use.

## Interface
- `BIT_WIDTH`, 8, operand width of `weight` and `inp`.
- `ACCUM_BITS`, 32, accumulator and result width.
- `LEN_BITS`, 16, width of the vector-length field.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request to begin a vector; sampled only in IDLE.
- `vec_len`  in  LEN_BITS  number of pairs in the vector; sampled with `start`.
- `init_sum`  in  ACCUM_BITS  initial accumulator value; sampled with `start`.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block accepts an operand pair.
- `weight`  in  BIT_WIDTH  unsigned weight.
- `inp`  in  BIT_WIDTH  unsigned activation.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  ACCUM_BITS  final accumulated sum.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Arithmetic:
  - All operands are unsigned.
  - Each accepted pair performs `acc <= acc + weight*inp` through the MAC instance.
  - The sum wraps modulo 2^ACCUM_BITS. No saturation, no overflow flag.
- Operand stage: an accepted pair is captured into registers `w_q`, `i_q` with flag `v_q`. The next edge applies the MAC to `acc` when `v_q` is set.
- FSM states are IDLE, ACCUM, DRAIN, DONE.
  - IDLE, `start` high, `vec_len` != 0: load `acc` = `init_sum` and `cnt` = `vec_len`, then go to ACCUM.
  - IDLE, `start` high, `vec_len` == 0: load `acc` = `init_sum`, then go directly to DONE.
  - ACCUM: `in_ready` = 1. On each transfer (`in_valid` & `in_ready`), `cnt` decrements. The transfer with `cnt` == 1 moves the FSM to DRAIN.
  - DRAIN: `in_ready` = 0. The final pending operand pair is accumulated, then the FSM goes to DONE.
  - DONE: `out_valid` = 1 and `out_sum` = `acc`. Both are held stable until `out_ready`. On the `out_valid` & `out_ready` edge, go to IDLE.
- `start` outside IDLE is ignored, and `vec_len`/`init_sum` are not sampled.
- `in_ready` is 0 in IDLE, DRAIN and DONE. `in_valid` in those states has no effect.
- `in_valid` low in ACCUM stalls the block indefinitely. `acc` still absorbs any pending `v_q` pair.
- Reset mid-operation: all state is discarded immediately and the FSM returns to IDLE. No partial result is emitted.

## Timing
- Reset values:
  - `in_ready` = 0, `out_valid` = 0, `out_sum` = 0, `busy` = 0.
  - Internally, `acc` = 0, `cnt` = 0, `v_q` = 0, state = IDLE.
- Throughput: one pair per cycle while `in_valid` is held high in ACCUM.
- Latency: final pair accepted at edge E, `acc` final at E+1, `out_valid` first high after edge E+2. A zero-length vector gives `out_valid` after the edge following `start` + 1.
- Minimum gap: the cycle after the DONE handshake is IDLE. A new `start` is accepted there.
- `out_sum` is a registered copy of `acc` and does not change while `out_valid` is high.

## Structure
- Shared package `mac_pkg` holds:
  - The state enum (IDLE/ACCUM/DRAIN/DONE).
  - Default constants `MAC_BIT_WIDTH` = 8, `MAC_ACCUM_BITS` = 32.
- One sub-module: the existing combinational MAC `top`, instantiated once. Its inputs are `weight` = `w_q`, `inp` = `i_q`, `partial_sum_in` = `acc`, and its output `partial_sum_out` feeds `acc`.
- FSM, counter and operand register live in `mac_seq_accum`.

## Test plan
- Reset then idle: assert `rst_n` low mid-cycle → all outputs 0 asynchronously. Stay idle 10 cycles → `busy` = 0, `out_valid` = 0.
- Basic vector: `vec_len` = 3, `init_sum` = 5, pairs (2,3), (4,5), (255,255), back-to-back → `out_sum` = 5+6+20+65025 = 65056. `out_valid` rises 2 cycles after the third accept.
- Backpressure both sides: `vec_len` = 4 with randomly gapped `in_valid` and `out_ready` held low 7 cycles → same result as gapless. `out_sum` is stable for all 7 cycles, and `start` pulsed during DONE is ignored.
- Zero length: `vec_len` = 0, `init_sum` = 0xDEADBEEF → `out_valid` one cycle after the IDLE→DONE transition, `out_sum` = 0xDEADBEEF. No `in_ready` pulse.
- Wrap-around: `init_sum` = 0xFFFF_FFF0, one pair (4,5) → `out_sum` = 0x0000_0004.
- Reset mid-vector: assert `rst_n` after 2 of 5 pairs → state IDLE, `out_valid` never asserts. A following `vec_len` = 1, `init_sum` = 0, pair (3,7) → `out_sum` = 21.
